lsu_tracker: RTL and testbench

- Downstream of the instruction-fetch tracker.
- Queues the load/store instruction words that the fetch tracker reports, then pairs each one, in order, with the next data-memory transaction observed on the core's data port.
- Emits one timestamped trace record per completed load/store, over a valid/ready handshake to the trace sink.
- Purely observational: never drives the data bus.

---
 rtl/gouram_trace_pkg.sv | 35 +++
 rtl/lsu_tracker_if.sv | 46 ++++
 rtl/trace_fifo.sv | 49 ++++
 rtl/lsu_tracker.sv | 173 +++++++++++++++++
 tb/tb_lsu_tracker.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gouram_trace_pkg.sv
// Shared types and constants for the load/store trace tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gouram_trace_pkg;

  // Record field widths; the tracker's width parameters must match these.
  localparam int LSU_DATA_W = 32;
  localparam int LSU_ADDR_W = 32;
  localparam int LSU_TIME_W = 32;

  // RISC-V major opcodes of the words the fetch tracker forwards.
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2,
    EMIT        = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic [LSU_DATA_W-1:0] instruction;
    logic [LSU_ADDR_W-1:0] addr;
    logic                  we;
    logic [LSU_TIME_W-1:0] req_time;
    logic [LSU_TIME_W-1:0] done_time;
  } lsu_trace_t;

  // True when an instruction word carries a load or store major opcode.
  function automatic logic is_lsu_opcode(input logic [LSU_DATA_W-1:0] word);
    return (word[6:0] == OPC_LOAD) || (word[6:0] == OPC_STORE);
  endfunction

endpackage

// File: rtl/lsu_tracker_if.sv
// Bundles the fetch-report, data-port snoop and trace-record signals.
// Latency: n/a (wiring only).
// Backpressure: trace_ready stalls the trace record; data port is snooped only.
interface lsu_tracker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIME_WIDTH = 32
) ();

  logic                  if_data_ready;
  logic [DATA_WIDTH-1:0] if_instruction;

  logic                  data_req;
  logic                  data_gnt;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic                  data_we;
  logic                  data_rvalid;

  logic                  trace_valid;
  logic                  trace_ready;
  logic [DATA_WIDTH-1:0] trace_instruction;
  logic [ADDR_WIDTH-1:0] trace_addr;
  logic                  trace_we;
  logic [TIME_WIDTH-1:0] trace_req_time;
  logic [TIME_WIDTH-1:0] trace_done_time;
  logic                  trace_lost;

  // Tracker side: observes everything, drives only the trace record.
  modport master (
    input  if_data_ready, if_instruction,
    input  data_req, data_gnt, data_addr, data_we, data_rvalid,
    input  trace_ready,
    output trace_valid, trace_instruction, trace_addr, trace_we,
    output trace_req_time, trace_done_time, trace_lost
  );

  // Environment side: fetch tracker, core data port and trace sink.
  modport slave (
    output if_data_ready, if_instruction,
    output data_req, data_gnt, data_addr, data_we, data_rvalid,
    output trace_ready,
    input  trace_valid, trace_instruction, trace_addr, trace_we,
    input  trace_req_time, trace_done_time, trace_lost
  );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO for pending instruction words, head visible combinationally.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | do_pop);
  assign pop_dat_o = mem_q[rptr_q[AW-1:0]];

  // Advance read/write pointers; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/lsu_tracker.sv
// Pairs queued load/store words with snooped data-port transactions, emits timestamped records.
// Latency: trace_valid rises one cycle after data_rvalid.
// Backpressure: record held stable until trace_ready; requests seen meanwhile are lost. Option: LSU_TRACKER_LOST_CNT_EN.
module lsu_tracker
  import gouram_trace_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIME_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_tracker_if.master  bus
`ifdef LSU_TRACKER_LOST_CNT_EN
  ,
  output logic [7:0]     lost_count
`endif
);

  lsu_state_t            state_q, state_d;
  logic [TIME_WIDTH-1:0] ts_q;
  logic                  we_q;
  logic [TIME_WIDTH-1:0] req_time_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  lsu_trace_t            trace_q;
  logic                  lost_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  logic                  cap_req;
  logic                  cap_addr;
  logic                  load_rec;
  logic                  pop;
  logic                  emit_drop;
  logic                  overflow_drop;

  // A push while full only survives if the head leaves in the same cycle.
  assign overflow_drop = bus.if_data_ready & fifo_full & ~pop;

  trace_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_pending (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (bus.if_data_ready),
    .push_dat_i (bus.if_instruction),
    .pop_i      (pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; a request with nothing queued is an orphan and is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.data_req && !fifo_empty) state_d = bus.data_gnt ? WAIT_RVALID : WAIT_GNT;
      end
      WAIT_GNT: begin
        if (bus.data_gnt) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (bus.data_rvalid) state_d = EMIT;
      end
      EMIT: begin
        if (bus.trace_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: capture strobes, queue pop and the in-EMIT drop event.
  always_comb begin
    cap_req   = 1'b0;
    cap_addr  = 1'b0;
    load_rec  = 1'b0;
    pop       = 1'b0;
    emit_drop = 1'b0;
    unique case (state_q)
      IDLE: begin
        cap_req  = bus.data_req & ~fifo_empty;
        cap_addr = bus.data_req & ~fifo_empty & bus.data_gnt;
      end
      WAIT_GNT: begin
        cap_addr = bus.data_gnt;
      end
      WAIT_RVALID: begin
        load_rec = bus.data_rvalid;
        pop      = bus.data_rvalid & ~fifo_empty;
      end
      EMIT: begin
        emit_drop = bus.data_req & ~fifo_empty;
      end
      default: ;
    endcase
  end

  // Free-running cycle timestamp, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  // Working capture of the tracked request: direction and time at req, address at gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      req_time_q <= '0;
      addr_q     <= '0;
    end else begin
      if (cap_req) begin
        we_q       <= bus.data_we;
        req_time_q <= ts_q;
      end
      if (cap_addr) addr_q <= bus.data_addr;
    end
  end

  // Outgoing record, loaded on completion and held until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_q <= '0;
    end else if (load_rec) begin
      trace_q.instruction <= fifo_head;
      trace_q.addr        <= addr_q;
      trace_q.we          <= we_q;
      trace_q.req_time    <= req_time_q;
      trace_q.done_time   <= ts_q;
    end
  end

  // Sticky loss flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lost_q <= 1'b0;
    else if (overflow_drop || emit_drop) lost_q <= 1'b1;
  end

`ifdef LSU_TRACKER_LOST_CNT_EN
  logic [7:0] lost_cnt_q;
  logic [8:0] lost_sum;

  // Both drop kinds can occur in one cycle, so add them before saturating.
  assign lost_sum = {1'b0, lost_cnt_q} + {8'd0, overflow_drop} + {8'd0, emit_drop};

  // Saturating count of drop events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lost_cnt_q <= '0;
    else        lost_cnt_q <= lost_sum[8] ? 8'hff : lost_sum[7:0];
  end

  assign lost_count = lost_cnt_q;
`endif

  assign bus.trace_valid       = (state_q == EMIT);
  assign bus.trace_instruction = trace_q.instruction;
  assign bus.trace_addr        = trace_q.addr;
  assign bus.trace_we          = trace_q.we;
  assign bus.trace_req_time    = trace_q.req_time;
  assign bus.trace_done_time   = trace_q.done_time;
  assign bus.trace_lost        = lost_q;

endmodule

// File: tb/tb_lsu_tracker.sv
// Directed bench for lsu_tracker: timing, backpressure, overflow, orphan and reset.
// Latency: n/a.
// Backpressure: exercised by holding trace_ready low.
module tb_lsu_tracker;
  import gouram_trace_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc;
`ifdef LSU_TRACKER_LOST_CNT_EN
  logic [7:0] lost_count;
`endif

  always #5 clk = ~clk;

  lsu_tracker_if bus ();

  lsu_tracker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LSU_TRACKER_LOST_CNT_EN
    ,
    .lost_count (lost_count)
`endif
  );

  // Scheduling reference: cycles since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Observed record: valid, instruction, addr, we, req_time, done_time.
  function automatic logic [129:0] obs();
    return {bus.trace_valid, bus.trace_instruction, bus.trace_addr, bus.trace_we,
            bus.trace_req_time, bus.trace_done_time};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic idle_inputs();
    bus.if_data_ready  = 1'b0;
    bus.if_instruction = '0;
    bus.data_req       = 1'b0;
    bus.data_gnt       = 1'b0;
    bus.data_addr      = '0;
    bus.data_we        = 1'b0;
    bus.data_rvalid    = 1'b0;
    bus.trace_ready    = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #3;
    checks++;
    if (obs() !== 130'd0) begin
      failures++;
      $display("FAIL reset_record: got %h required 0", obs());
    end
    checks++;
    if (bus.trace_lost !== 1'b0) begin
      failures++;
      $display("FAIL reset_lost: got %b required 0", bus.trace_lost);
    end
`ifdef LSU_TRACKER_LOST_CNT_EN
    checks++;
    if (lost_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_lost_count: got %0d required 0", lost_count);
    end
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    goto(10);
    bus.if_data_ready = 1'b1; bus.if_instruction = 32'h0000a083;
    step();
    bus.if_data_ready = 1'b0;
    goto(12);
    bus.data_req = 1'b1; bus.data_gnt = 1'b1; bus.data_addr = 32'h1000; bus.data_we = 1'b0;
    step();
    bus.data_req = 1'b0; bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1;
    checks++;
    if (bus.trace_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_wait_early_valid: got %b required 0", bus.trace_valid);
    end
    step();
    bus.data_rvalid = 1'b0;
    checks++;
    if (obs() !== {1'b1, 32'h0000a083, 32'h1000, 1'b0, 32'd12, 32'd13}) begin
      failures++;
      $display("FAIL zero_wait_record: got %h required %h", obs(),
               {1'b1, 32'h0000a083, 32'h1000, 1'b0, 32'd12, 32'd13});
    end
    step();
    checks++;
    if (bus.trace_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_wait_handshake: got valid %b required 0", bus.trace_valid);
    end
  endtask

  task automatic test_delayed_gnt();
    goto(16);
    bus.if_data_ready = 1'b1; bus.if_instruction = 32'h00112023;
    step();
    bus.if_data_ready = 1'b0;
    goto(20);
    bus.data_req = 1'b1; bus.data_addr = 32'h2004; bus.data_we = 1'b1;
    goto(23);
    bus.data_gnt = 1'b1;
    step();
    bus.data_req = 1'b0; bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1;
    step();
    bus.data_rvalid = 1'b0;
    checks++;
    if (obs() !== {1'b1, 32'h00112023, 32'h2004, 1'b1, 32'd20, 32'd24}) begin
      failures++;
      $display("FAIL delayed_gnt_record: got %h required %h", obs(),
               {1'b1, 32'h00112023, 32'h2004, 1'b1, 32'd20, 32'd24});
    end
    checks++;
    if (bus.trace_lost !== 1'b0) begin
      failures++;
      $display("FAIL delayed_gnt_lost: got %b required 0", bus.trace_lost);
    end
  endtask

  task automatic test_backpressure();
    goto(30);
    bus.trace_ready = 1'b0;
    bus.if_data_ready = 1'b1; bus.if_instruction = 32'h00312283;
    step();
    bus.if_instruction = 32'h00512423;
    step();
    bus.if_data_ready = 1'b0;
    goto(33);
    bus.data_req = 1'b1; bus.data_gnt = 1'b1; bus.data_addr = 32'h3008; bus.data_we = 1'b0;
    step();
    bus.data_req = 1'b0; bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1;
    step();
    bus.data_rvalid = 1'b0;
    checks++;
    if (bus.trace_lost !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_lost_before: got %b required 0", bus.trace_lost);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs() !== {1'b1, 32'h00312283, 32'h3008, 1'b0, 32'd33, 32'd34}) begin
        failures++;
        $display("FAIL backpressure_hold_%0d: got %h required %h", i, obs(),
                 {1'b1, 32'h00312283, 32'h3008, 1'b0, 32'd33, 32'd34});
      end
      if (i == 2) begin
        bus.data_req = 1'b1; bus.data_gnt = 1'b1; bus.data_addr = 32'hdead0000; bus.data_we = 1'b1;
      end else if (i == 3) begin
        bus.data_req = 1'b0; bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1;
      end else if (i == 4) begin
        bus.data_rvalid = 1'b0;
      end
      step();
    end
    checks++;
    if (bus.trace_lost !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_lost_after: got %b required 1", bus.trace_lost);
    end
    bus.trace_ready = 1'b1;
    checks++;
    if (bus.trace_valid !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_valid_at_ready: got %b required 1", bus.trace_valid);
    end
    step();
    checks++;
    if (bus.trace_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: got %b required 0", bus.trace_valid);
    end
    goto(43);
    bus.data_req = 1'b1; bus.data_addr = 32'h300c; bus.data_we = 1'b1;
    step();
    bus.data_gnt = 1'b1;
    step();
    bus.data_req = 1'b0; bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1;
    step();
    bus.data_rvalid = 1'b0;
    checks++;
    if (obs() !== {1'b1, 32'h00512423, 32'h300c, 1'b1, 32'd43, 32'd45}) begin
      failures++;
      $display("FAIL backpressure_next_record: got %h required %h", obs(),
               {1'b1, 32'h00512423, 32'h300c, 1'b1, 32'd43, 32'd45});
    end
  endtask

  task automatic test_overflow();
    logic [31:0] words [5];
    words[0] = 32'h00002003; words[1] = 32'h00402023; words[2] = 32'h00802083;
    words[3] = 32'h00c02123; words[4] = 32'h01002183;
    do_reset();
    goto(2);
    for (int i = 0; i < 5; i++) begin
      bus.if_data_ready = 1'b1; bus.if_instruction = words[i];
      if (i == 4) begin
        checks++;
        if (bus.trace_lost !== 1'b0) begin
          failures++;
          $display("FAIL overflow_lost_at_full: got %b required 0", bus.trace_lost);
        end
      end
      step();
    end
    bus.if_data_ready = 1'b0;
    checks++;
    if (bus.trace_lost !== 1'b1) begin
      failures++;
      $display("FAIL overflow_lost: got %b required 1", bus.trace_lost);
    end
`ifdef LSU_TRACKER_LOST_CNT_EN
    checks++;
    if (lost_count !== 8'd1) begin
      failures++;
      $display("FAIL overflow_lost_count: got %0d required 1", lost_count);
    end
`endif
    for (int k = 0; k < 5; k++) begin
      goto(10 + 4 * k);
      bus.data_req = 1'b1; bus.data_gnt = 1'b1; bus.data_addr = 32'h4000 + 32'(4 * k); bus.data_we = 1'b0;
      step();
      bus.data_req = 1'b0; bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1;
      step();
      bus.data_rvalid = 1'b0;
      checks++;
      if (k < 4) begin
        if (obs() !== {1'b1, words[k], 32'h4000 + 32'(4 * k), 1'b0, 32'(10 + 4 * k), 32'(11 + 4 * k)}) begin
          failures++;
          $display("FAIL overflow_order_%0d: got %h required %h", k, obs(),
                   {1'b1, words[k], 32'h4000 + 32'(4 * k), 1'b0, 32'(10 + 4 * k), 32'(11 + 4 * k)});
        end
      end else begin
        if (bus.trace_valid !== 1'b0) begin
          failures++;
          $display("FAIL overflow_fifth_word: got valid %b instr %h required no record",
                   bus.trace_valid, bus.trace_instruction);
        end
      end
    end
  endtask

  task automatic test_orphan_reset();
    do_reset();
    goto(3);
    bus.data_req = 1'b1; bus.data_gnt = 1'b1; bus.data_addr = 32'h5000;
    step();
    bus.data_req = 1'b0; bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1;
    step();
    bus.data_rvalid = 1'b0;
    checks++;
    if ({bus.trace_valid, bus.trace_lost} !== 2'b00) begin
      failures++;
      $display("FAIL orphan_no_record: got valid/lost %b required 00", {bus.trace_valid, bus.trace_lost});
    end
    goto(8);
    for (int i = 0; i < 5; i++) begin
      bus.if_data_ready = 1'b1; bus.if_instruction = 32'h00a00003 + 32'(i << 20);
      step();
    end
    bus.if_data_ready = 1'b0;
    goto(14);
    bus.data_req = 1'b1; bus.data_gnt = 1'b1; bus.data_addr = 32'h6000; bus.data_we = 1'b1;
    step();
    bus.data_req = 1'b0; bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1;
    step();
    bus.data_rvalid = 1'b0;
    checks++;
    if ({obs(), bus.trace_lost} !== {1'b1, 32'h00a00003, 32'h6000, 1'b1, 32'd14, 32'd15, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset_record: got %h required %h", {obs(), bus.trace_lost},
               {1'b1, 32'h00a00003, 32'h6000, 1'b1, 32'd14, 32'd15, 1'b1});
    end
    goto(18);
    bus.data_req = 1'b1; bus.data_gnt = 1'b1; bus.data_addr = 32'h7000; bus.data_we = 1'b0;
    step();
    bus.data_req = 1'b0; bus.data_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs(), bus.trace_lost} !== 131'd0) begin
      failures++;
      $display("FAIL async_reset_outputs: got %h required 0", {obs(), bus.trace_lost});
    end
`ifdef LSU_TRACKER_LOST_CNT_EN
    checks++;
    if (lost_count !== 8'd0) begin
      failures++;
      $display("FAIL async_reset_lost_count: got %0d required 0", lost_count);
    end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.data_rvalid = 1'b1;
    step();
    bus.data_rvalid = 1'b0;
    bus.data_req = 1'b1; bus.data_gnt = 1'b1; bus.data_addr = 32'h8000;
    checks++;
    if (bus.trace_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_stale_rvalid: got valid %b required 0", bus.trace_valid);
    end
    step();
    bus.data_req = 1'b0; bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1;
    step();
    bus.data_rvalid = 1'b0;
    checks++;
    if ({bus.trace_valid, bus.trace_lost} !== 2'b00) begin
      failures++;
      $display("FAIL reset_fifo_empty: got valid/lost %b required 00", {bus.trace_valid, bus.trace_lost});
    end
  endtask

`ifdef LSU_TRACKER_LOST_CNT_EN
  task automatic test_lost_count();
    do_reset();
    goto(1);
    bus.if_data_ready = 1'b1; bus.if_instruction = 32'h00002003;
    for (int i = 1; i <= 304; i++) begin
      step();
      if (i == 104) begin
        checks++;
        if (lost_count !== 8'd100) begin
          failures++;
          $display("FAIL lost_count_mid: got %0d required 100", lost_count);
        end
      end
    end
    bus.if_data_ready = 1'b0;
    checks++;
    if (lost_count !== 8'd255) begin
      failures++;
      $display("FAIL lost_count_saturate: got %0d required 255", lost_count);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed_gnt();
    test_backpressure();
    test_overflow();
    test_orphan_reset();
`ifdef LSU_TRACKER_LOST_CNT_EN
    test_lost_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
